gpio_in: RTL and testbench
==========================

GPIO_IN -- requirements
Module: gpio_in

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd5004, which is the byte address of register IN; registers are at BASE_ADDR+0/4/8/12.
REQ-002 SHALL have parameter DEBOUNCE_RST, default 16'd4, which is the reset value of CFG.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port busAddrIn, input, width 32: CPU bus byte address.
REQ-006 SHALL have port busDataIn, input, width 32: CPU write data.
REQ-007 SHALL have port busWEIn, input, width 1: CPU write strobe, one cycle per write.
REQ-008 SHALL have port busDataOut, output, width 32: read data, combinational from busAddrIn and internal registers.
REQ-009 SHALL have port pinsIn, input, width 8: asynchronous external input pins.

Function
REQ-010 SHALL register map as follows: IN (+0, RO) = debounced state in bits [7:0]; RISE (+4, W1C) = sticky rising-edge flags in [7:0]; FALL (+8, W1C) = sticky falling-edge flags in [7:0]; CFG (+12, RW) = debounce threshold in [15:0].
REQ-011 SHALL drive busDataOut to the addressed register zero-extended to 32 bits, and to 32'd0 for any address outside the four registers; reads have no side effects.
REQ-012 SHALL pass each pin through a 2-flop synchronizer (sync1<=pinsIn, sync2<=sync1).
REQ-013 SHALL keep one 16-bit counter per pin: if sync2!=deb and cnt<CFG, then cnt+1; if sync2!=deb and cnt>=CFG, then deb<=sync2 and cnt<=0; if sync2==deb, then cnt<=0.
REQ-014 SHALL give the following latency: a pin change set up before edge 1 appears in sync2 after edge 2 and in deb after edge 3+CFG, provided the pin stays stable throughout; CFG=0 gives 3 cycles.
REQ-015 SHALL, when a pin glitch is shorter than CFG+1 cycles at sync2, leave deb unchanged and reset that pin's counter.
REQ-016 SHALL, on the edge where deb[i] goes 0->1, set RISE[i], and on the edge where deb[i] goes 1->0, set FALL[i]; flags remain set until cleared.
REQ-017 SHALL, on a write to RISE or FALL, clear bits where busDataIn[i]=1 and leave bits where busDataIn[i]=0 unchanged.
REQ-018 SHALL give set priority over clear: if an edge set and a W1C clear hit the same bit in the same cycle, the bit ends 1.
REQ-019 SHALL, on a write to CFG, load busDataIn[15:0], effective from the next edge; running counters are kept and compared against the new value, so cnt>=new CFG updates deb on the next differing edge.
REQ-020 SHALL ignore writes to IN and to unmapped addresses; writes SHALL act only when busWEIn=1 and the address matches exactly.
REQ-021 SHALL treat address matching as full 32-bit equality, with no aliasing.

Reset
REQ-022 SHALL, while rst=1 at an edge, set sync1, sync2, deb, RISE, FALL and all counters to 0, and set CFG to DEBOUNCE_RST.
REQ-023 SHALL give rst priority over bus writes and debounce updates in the same cycle; reset mid-count discards the pending change.
REQ-024 SHALL, after reset with a pin held high, debounce that pin normally and set RISE for it.
REQ-025 SHALL make busDataOut reflect the reset register values in the cycle following the reset edge.

Verification
REQ-026 SHALL cover: reset, then read +0/+4/+8/+12 -> 0, 0, 0, 32'd4; read BASE_ADDR+16 -> 0.
REQ-027 SHALL cover: CFG=4, pinsIn 8'h00->8'h01 held -> IN=1 exactly 7 edges after the change; RISE=32'h1, FALL=0.
REQ-028 SHALL cover: CFG=4, pin0 high pulse of 3 cycles -> IN stays 0 and RISE stays 0; a 5-cycle pulse -> IN rises, then falls, and RISE=FALL=1.
REQ-029 SHALL cover: RISE=8'h03, write RISE 32'h1 -> RISE=8'h02; a W1C of bit1 on the same edge that bit1 rises -> bit1 stays 1.
REQ-030 SHALL cover: write CFG=0 -> deb follows a change in 3 cycles; CFG 100->2 while cnt=10 -> deb updates on the next edge.
REQ-031 SHALL cover: rst asserted mid-debounce (cnt=3) -> after reset IN=0, CFG=4, and the counter restarts from 0.

Source files
------------

// File: rtl/gpio_in.sv
// gpio_in: eight asynchronous input pins, each passed through a 2-flop
// synchronizer and a per-pin debounce counter. The debounced state and
// sticky rise/fall flags are exposed on a simple CPU register bus.
module gpio_in #(
  parameter logic [31:0] BASE_ADDR    = 32'd5004,
  parameter logic [15:0] DEBOUNCE_RST = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] busAddrIn,
  input  logic [31:0] busDataIn,
  input  logic        busWEIn,
  output logic [31:0] busDataOut,
  input  logic [7:0]  pinsIn
);

  localparam logic [31:0] ADDR_IN   = BASE_ADDR;
  localparam logic [31:0] ADDR_RISE = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_FALL = BASE_ADDR + 32'd8;
  localparam logic [31:0] ADDR_CFG  = BASE_ADDR + 32'd12;

  logic [7:0]  sync1_q;
  logic [7:0]  sync2_q;
  logic [7:0]  deb_q;
  logic [7:0]  deb_d;
  logic [7:0]  rise_q;
  logic [7:0]  rise_d;
  logic [7:0]  fall_q;
  logic [7:0]  fall_d;
  logic [15:0] cfg_q;
  logic [15:0] cfg_d;
  logic [15:0] cnt_q [8];
  logic [15:0] cnt_d [8];

  logic        wr_rise_s;
  logic        wr_fall_s;
  logic        wr_cfg_s;
  logic [7:0]  rise_clr_s;
  logic [7:0]  fall_clr_s;

  // Write decode: a write acts only on an exact 32-bit address match.
  always_comb begin
    wr_rise_s  = busWEIn && (busAddrIn == ADDR_RISE);
    wr_fall_s  = busWEIn && (busAddrIn == ADDR_FALL);
    wr_cfg_s   = busWEIn && (busAddrIn == ADDR_CFG);
    rise_clr_s = wr_rise_s ? busDataIn[7:0] : 8'd0;
    fall_clr_s = wr_fall_s ? busDataIn[7:0] : 8'd0;
  end

  // Per-pin debounce: count consecutive cycles where the synchronized pin
  // differs from the debounced state; accept the new level once the count
  // has reached the threshold, and restart the count on any agreement.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] >= cfg_q) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = 16'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end else begin
        cnt_d[i] = 16'd0;
      end
    end
  end

  // Sticky edge flags and threshold: a new edge is applied after the W1C
  // mask so that an edge arriving with a clear leaves the flag set.
  always_comb begin
    rise_d = (rise_q & ~rise_clr_s) | (deb_d & ~deb_q);
    fall_d = (fall_q & ~fall_clr_s) | (~deb_d & deb_q);
    cfg_d  = wr_cfg_s ? busDataIn[15:0] : cfg_q;
  end

  // State registers; reset overrides every bus write and debounce update.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
      deb_q   <= 8'd0;
      rise_q  <= 8'd0;
      fall_q  <= 8'd0;
      cfg_q   <= DEBOUNCE_RST;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      sync1_q <= pinsIn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cfg_q   <= cfg_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Read mux: combinational, side-effect free, zero outside the map.
  always_comb begin
    busDataOut = 32'd0;
    case (busAddrIn)
      ADDR_IN:   busDataOut = {24'd0, deb_q};
      ADDR_RISE: busDataOut = {24'd0, rise_q};
      ADDR_FALL: busDataOut = {24'd0, fall_q};
      ADDR_CFG:  busDataOut = {16'd0, cfg_q};
      default:   busDataOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_gpio_in.sv
// tb_gpio_in: directed vector table for the register map, latency and W1C
// behaviour, followed by hand-written glitch, threshold and reset sequences.
module tb_gpio_in;

  localparam logic [31:0] B = 32'd5004;

  logic        clk;
  logic        rst;
  logic [31:0] busAddrIn;
  logic [31:0] busDataIn;
  logic        busWEIn;
  logic [31:0] busDataOut;
  logic [7:0]  pinsIn;

  int ntests;
  int nfail;

  typedef struct {
    logic        adv;    // 1: apply inputs and clock one edge first
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  pins;
    logic [31:0] raddr;  // address read back after the (optional) edge
    logic [31:0] exp;
    logic [63:0] tag;
  } vec_t;

  vec_t vecs[$];

  gpio_in #(.BASE_ADDR(B), .DEBOUNCE_RST(16'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .busAddrIn (busAddrIn),
    .busDataIn (busDataIn),
    .busWEIn   (busWEIn),
    .busDataOut(busDataOut),
    .pinsIn    (pinsIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [63:0] tag, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %0s: got 32'h%08h, expected 32'h%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [63:0] tag, input logic [31:0] addr, input logic [31:0] exp);
    busAddrIn = addr;
    #1;
    check(tag, busDataOut, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    busAddrIn = addr;
    busDataIn = data;
    busWEIn   = 1'b1;
    tick();
    busWEIn   = 1'b0;
  endtask

  task automatic add(input logic adv, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] pins,
                     input logic [31:0] raddr, input logic [31:0] exp,
                     input logic [63:0] tag);
    vec_t v;
    v.adv = adv; v.we = we; v.addr = addr; v.wdata = wdata;
    v.pins = pins; v.raddr = raddr; v.exp = exp; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    busWEIn = 1'b0;
    pinsIn  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    ntests    = 0;
    nfail     = 0;
    busAddrIn = 32'd0;
    busDataIn = 32'd0;
    busWEIn   = 1'b0;
    pinsIn    = 8'h00;
    do_reset();

    // Reset values, read without advancing the clock.
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h00, B,          32'd0, "rst_in");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h00, B + 32'd4,  32'd0, "rst_rise");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h00, B + 32'd8,  32'd0, "rst_fall");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h00, B + 32'd12, 32'd4, "rst_cfg");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h00, B + 32'd16, 32'd0, "unmapped");
    // Pin0 0->1 with CFG=4: IN goes high on the 7th edge.
    for (int e = 1; e <= 6; e++) add(1'b1, 1'b0, 32'd0, 32'd0, 8'h01, B, 32'd0, "lat_in");
    add(1'b1, 1'b0, 32'd0, 32'd0, 8'h01, B,         32'd1, "lat_in7");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h01, B + 32'd4, 32'd1, "rise1");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h01, B + 32'd8, 32'd0, "fall0");
    // Pin1 rises too, giving RISE=3.
    for (int e = 1; e <= 6; e++) add(1'b1, 1'b0, 32'd0, 32'd0, 8'h03, B, 32'd1, "p1_in");
    add(1'b1, 1'b0, 32'd0, 32'd0, 8'h03, B,         32'd3, "p1_in7");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h03, B + 32'd4, 32'd3, "rise3");
    // W1C of bit0 only, then clear everything.
    add(1'b1, 1'b1, B + 32'd4, 32'd1,          8'h03, B + 32'd4, 32'd2, "w1c");
    add(1'b1, 1'b1, B + 32'd4, 32'hFFFF_FFFF,  8'h03, B + 32'd4, 32'd0, "w1c_all");
    // Pin1 falls: FALL bit1 set.
    for (int e = 1; e <= 6; e++) add(1'b1, 1'b0, 32'd0, 32'd0, 8'h01, B, 32'd3, "p1fall");
    add(1'b1, 1'b0, 32'd0, 32'd0, 8'h01, B,         32'd1, "p1fall7");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h01, B + 32'd8, 32'd2, "fall2");
    // Pin1 rises again with a W1C of bit1 on the very edge it sets.
    for (int e = 1; e <= 6; e++) add(1'b1, 1'b0, 32'd0, 32'd0, 8'h03, B, 32'd1, "p1rise");
    add(1'b1, 1'b1, B + 32'd4, 32'd2, 8'h03, B + 32'd4, 32'd2, "setwins");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h03, B, 32'd3, "in3");
    // FALL W1C, ignored writes, aliasing and CFG load.
    add(1'b1, 1'b1, B + 32'd8,              32'd2,          8'h03, B + 32'd8,  32'd0, "w1c_fall");
    add(1'b1, 1'b1, B,                      32'd0,          8'h03, B,          32'd3, "wr_in");
    add(1'b1, 1'b1, B + 32'd12 + 32'h10000, 32'd0,          8'h03, B + 32'd12, 32'd4, "alias");
    add(1'b1, 1'b1, B + 32'd16,             32'd0,          8'h03, B + 32'd12, 32'd4, "wr_unmap");
    add(1'b1, 1'b1, B + 32'd12,             32'h0001_0007,  8'h03, B + 32'd12, 32'd7, "cfg_wr");
    add(1'b0, 1'b0, 32'd0, 32'd0, 8'h03, B + 32'd12 + 32'h10000, 32'd0, "rd_alias");
    add(1'b1, 1'b1, B + 32'd12,             32'd4,          8'h03, B + 32'd12, 32'd4, "cfg4");

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].adv) begin
        busWEIn   = vecs[k].we;
        busAddrIn = vecs[k].addr;
        busDataIn = vecs[k].wdata;
        pinsIn    = vecs[k].pins;
        tick();
        busWEIn   = 1'b0;
      end
      rd(vecs[k].tag, vecs[k].raddr, vecs[k].exp);
    end

    // Glitch filtering with CFG=4: a 3-cycle pulse is dropped, a 5-cycle
    // pulse passes (IN high after edges 7..11).
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      pinsIn = (e <= 3) ? 8'h01 : 8'h00;
      tick();
      rd("glitch3", B, 32'd0);
    end
    rd("g3_rise", B + 32'd4, 32'd0);
    for (int e = 1; e <= 14; e++) begin
      pinsIn = (e <= 5) ? 8'h01 : 8'h00;
      tick();
      rd("pulse5", B, (e >= 7 && e <= 11) ? 32'd1 : 32'd0);
    end
    rd("p5_rise", B + 32'd4, 32'd1);
    rd("p5_fall", B + 32'd8, 32'd1);

    // CFG=0: pin7 follows in 3 edges.
    wr(B + 32'd12, 32'd0);
    pinsIn = 8'h80;
    for (int e = 1; e <= 3; e++) begin
      tick();
      rd("cfg0", B, (e >= 3) ? 32'h80 : 32'd0);
    end

    // CFG=100, count to 10, then lower CFG to 2: IN updates one edge later.
    wr(B + 32'd12, 32'd100);
    pinsIn = 8'h00;
    for (int e = 1; e <= 12; e++) tick();
    rd("cnt10", B, 32'h80);
    wr(B + 32'd12, 32'd2);
    rd("cfg_edge", B, 32'h80);
    tick();
    rd("cfg_lower", B, 32'd0);

    // Reset mid-debounce (cnt=3), together with a CFG write that must lose.
    do_reset();
    pinsIn = 8'h01;
    for (int e = 1; e <= 5; e++) tick();
    rst       = 1'b1;
    busAddrIn = B + 32'd12;
    busDataIn = 32'd9;
    busWEIn   = 1'b1;
    tick();
    rst     = 1'b0;
    busWEIn = 1'b0;
    rd("mid_in",  B,          32'd0);
    rd("mid_cfg", B + 32'd12, 32'd4);
    rd("mid_rise", B + 32'd4, 32'd0);
    for (int e = 1; e <= 7; e++) begin
      tick();
      rd("restart", B, (e >= 7) ? 32'd1 : 32'd0);
    end
    rd("rst_rise1", B + 32'd4, 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
